seq_tx: RTL and testbench

SEQ_TX -- requirements
Module: seq_tx

---
 rtl/seq_tx.sv | 111 +++++++++++
 tb/tb_seq_tx.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_tx.sv
// seq_tx: parallel-in, serial-out frame transmitter.
// A frame is accepted in IDLE, shifted out MSB first, then followed by a fixed idle gap.
// Every output is driven straight from a flop.
module seq_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [3:0]      GapLast = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic [3:0]      r_gap;
  logic [3:0]      w_gap_next;
  logic            r_in_ready;
  logic            w_in_ready_next;
  logic            r_out_valid;
  logic            w_out_valid_next;
  logic            r_done;
  logic            w_done_next;
  logic            w_accept;

  // Handshake only qualifies against the registered ready, so reset edges never accept.
  assign w_accept = in_valid & r_in_ready;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_gap_next   = r_gap;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_shift_next = in_data;
          w_cnt_next   = '0;
          w_state_next = StShift;
        end
      end
      StShift: begin
        // Zero fill leaves the register empty once the frame is out, so out stays 0 after it.
        w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        if (r_cnt == CntLast) begin
          w_cnt_next   = '0;
          w_gap_next   = '0;
          w_state_next = (GAP_CYCLES > 0) ? StGap : StIdle;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StGap: begin
        if (r_gap == GapLast) begin
          w_gap_next   = '0;
          w_state_next = StIdle;
        end else begin
          w_gap_next = r_gap + 4'd1;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
    w_in_ready_next  = (w_state_next == StIdle);
    w_out_valid_next = (w_state_next == StShift);
    w_done_next      = (w_state_next == StShift) && (w_cnt_next == CntLast);
  end

  // State, datapath and output flops; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_cnt       <= w_cnt_next;
      r_gap       <= w_gap_next;
      r_in_ready  <= w_in_ready_next;
      r_out_valid <= w_out_valid_next;
      r_done      <= w_done_next;
    end
  end

  assign in_ready  = r_in_ready;
  assign out       = r_shift[WIDTH-1];
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: directed scenarios plus randomized traffic and loopback.
module tb_seq_tx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic va, vb;
  logic [W-1:0] da, db;
  logic ra, oa, ova, dna;
  logic rb, ob, ovb, dnb;

  always #5 clk = ~clk;

  seq_tx #(.WIDTH(W), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_data(da),
    .in_ready(ra), .out(oa), .out_valid(ova), .done(dna)
  );

  seq_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_data(db),
    .in_ready(rb), .out(ob), .out_valid(ovb), .done(dnb)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position within the frame period (0 idle, 1..W bits, W+1..W+G gap).
  int           m_pos  [2];
  logic [W-1:0] m_pay  [2];
  bit           m_fresh[2];
  logic [W-1:0] m_acc_q[$];

  function automatic int gap_of(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Expected {in_ready, out_valid, out, done}.
  function automatic logic [3:0] exp_of(int i);
    logic r, v, o, d;
    r = (m_pos[i] == 0) && !m_fresh[i];
    v = (m_pos[i] >= 1) && (m_pos[i] <= W);
    o = 1'b0;
    if (v) o = m_pay[i][W - m_pos[i]];
    d = (m_pos[i] == W);
    return {r, v, o, d};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i]   = 0;
      m_fresh[i] = 1'b1;
    end
  endtask

  // Advance one clock; the model sees the same inputs the DUT sees on this edge.
  task automatic step();
    logic         vin;
    logic [W-1:0] din;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        vin = (i == 0) ? va : vb;
        din = (i == 0) ? da : db;
        if (m_pos[i] == 0) begin
          if (!m_fresh[i] && vin) begin
            m_pos[i] = 1;
            m_pay[i] = din;
            if (i == 0) m_acc_q.push_back(din);
          end
        end else if (m_pos[i] >= W + gap_of(i)) begin
          m_pos[i] = 0;
        end else begin
          m_pos[i] = m_pos[i] + 1;
        end
        m_fresh[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle_wait();
    va = 1'b0;
    vb = 1'b0;
    for (int k = 0; k < 2 * W + 8; k++) begin
      if (m_pos[0] == 0 && m_pos[1] == 0) break;
      step();
    end
  endtask

  task automatic test_reset();
    va = 1'b1; vb = 1'b1; da = 8'hFF; db = 8'hFF;
    rst = 1'b1;
    m_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({ra, ova, oa, dna} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_a cyc%0d got %b want 0000", k, {ra, ova, oa, dna});
      end
      checks++;
      if ({rb, ovb, ob, dnb} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_b cyc%0d got %b want 0000", k, {rb, ovb, ob, dnb});
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if ({ra, ova, oa, dna} !== exp_of(0)) begin
      errors++;
      $display("FAIL reset_release_a got %b want %b", {ra, ova, oa, dna}, exp_of(0));
    end
    checks++;
    if (rb !== 1'b1 || ovb !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_b ready/valid got %b%b want 10", rb, ovb);
    end
    va = 1'b0; vb = 1'b0;
  endtask

  task automatic test_single();
    logic [W-1:0] bits;
    int dones, done_k;
    va = 1'b1; da = 8'hB4;
    step();
    va = 1'b0; da = W'($urandom);
    bits = '0; dones = 0; done_k = -1;
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if ({ra, ova, oa, dna} !== exp_of(0)) begin
        errors++;
        $display("FAIL single cyc%0d got %b want %b", k, {ra, ova, oa, dna}, exp_of(0));
      end
      if (ova) bits = {bits[W-2:0], oa};
      if (dna) begin dones++; done_k = k; end
      step();
    end
    checks++;
    if (bits !== 8'hB4) begin
      errors++; $display("FAIL single_stream got %h want b4", bits);
    end
    checks++;
    if (dones != 1 || done_k != 8) begin
      errors++; $display("FAIL single_done got count %0d at %0d want 1 at 8", dones, done_k);
    end
    checks++;
    if (ra !== 1'b1) begin
      errors++; $display("FAIL single_ready_t11 got %b want 1", ra);
    end
  endtask

  task automatic test_held_valid();
    int nstart, st1, st2;
    logic [W-1:0] b2;
    logic pv;
    va = 1'b1; da = 8'hFF;
    step();
    da = 8'h01;
    nstart = 0; st1 = -1; st2 = -1; b2 = '0; pv = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      checks++;
      if ({ra, ova, oa, dna} !== exp_of(0)) begin
        errors++;
        $display("FAIL held cyc%0d got %b want %b", k, {ra, ova, oa, dna}, exp_of(0));
      end
      if (ova) begin
        if (!pv) begin
          nstart++;
          if (nstart == 1) st1 = k;
          if (nstart == 2) st2 = k;
        end
        if (nstart == 2) b2 = {b2[W-2:0], oa};
      end
      pv = ova;
      if (k == 22) va = 1'b0;
      step();
    end
    checks++;
    if (st2 - st1 != 11) begin
      errors++; $display("FAIL held_spacing got %0d want 11", st2 - st1);
    end
    checks++;
    if (b2 !== 8'h01) begin
      errors++; $display("FAIL held_second_frame got %h want 01", b2);
    end
    idle_wait();
  endtask

  task automatic test_ignored_input();
    logic [W-1:0] bits;
    int dones;
    va = 1'b1; da = 8'hAA;
    step();
    va = 1'b0;
    bits = '0; dones = 0;
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if ({ra, ova, oa, dna} !== exp_of(0)) begin
        errors++;
        $display("FAIL ignored cyc%0d got %b want %b", k, {ra, ova, oa, dna}, exp_of(0));
      end
      if (ova) bits = {bits[W-2:0], oa};
      if (dna) dones++;
      va = (k == 3);
      da = (k == 3) ? 8'h00 : 8'hAA;
      step();
    end
    checks++;
    if (bits !== 8'hAA || dones != 1) begin
      errors++; $display("FAIL ignored_stream got %h/%0d want aa/1", bits, dones);
    end
    idle_wait();
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] bits;
    int dones;
    va = 1'b1; da = 8'hC3;
    step();
    va = 1'b0;
    step(); step();
    checks++;
    if (ova !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got valid %b want 1", ova);
    end
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    checks++;
    if ({ova, oa, dna, ra} !== 4'b0000) begin
      errors++; $display("FAIL midrst_async got %b want 0000", {ova, oa, dna, ra});
    end
    va = 1'b1; da = 8'hFF;
    step(); step();
    checks++;
    if ({ra, ova, oa, dna} !== 4'b0000) begin
      errors++; $display("FAIL midrst_hold got %b want 0000", {ra, ova, oa, dna});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({ra, ova, oa, dna} !== exp_of(0)) begin
      errors++;
      $display("FAIL midrst_release got %b want %b", {ra, ova, oa, dna}, exp_of(0));
    end
    da = 8'h81;
    step();
    va = 1'b0;
    bits = '0; dones = 0;
    for (int k = 1; k <= 10; k++) begin
      if (ova) bits = {bits[W-2:0], oa};
      if (dna) dones++;
      step();
    end
    checks++;
    if (bits !== 8'h81 || dones != 1) begin
      errors++; $display("FAIL midrst_next got %h/%0d want 81/1", bits, dones);
    end
    idle_wait();
  endtask

  task automatic test_gap0();
    logic [W-1:0] bits;
    int rdy_between, st2;
    vb = 1'b1; db = 8'h5A;
    step();
    db = W'($urandom);
    bits = '0; rdy_between = 0; st2 = -1;
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if ({rb, ovb, ob, dnb} !== exp_of(1)) begin
        errors++;
        $display("FAIL gap0 cyc%0d got %b want %b", k, {rb, ovb, ob, dnb}, exp_of(1));
      end
      if (k <= W && ovb) bits = {bits[W-2:0], ob};
      if (k > W && st2 < 0 && rb) rdy_between++;
      if (k > W && st2 < 0 && ovb) st2 = k;
      if (k == 10) vb = 1'b0;
      step();
    end
    checks++;
    if (bits !== 8'h5A) begin
      errors++; $display("FAIL gap0_stream got %h want 5a", bits);
    end
    checks++;
    if (rdy_between != 1 || st2 != W + 2) begin
      errors++; $display("FAIL gap0_idle got %0d idle, next at %0d want 1, %0d",
                         rdy_between, st2, W + 2);
    end
    idle_wait();
  endtask

  // Random traffic on both instances; dut_a also feeds a 1011 overlapping detector.
  task automatic test_random_loopback();
    logic [3:0] hist;
    int nb, det_dut, det_ref, rnb;
    logic [3:0] rh;
    logic [W-1:0] p;
    hist = '0; nb = 0; det_dut = 0;
    m_acc_q.delete();
    for (int k = 0; k < 400; k++) begin
      va = ($urandom_range(0, 3) != 0);
      vb = ($urandom_range(0, 1) != 0);
      da = W'($urandom);
      db = W'($urandom);
      step();
      checks++;
      if ({ra, ova, oa, dna} !== exp_of(0)) begin
        errors++;
        $display("FAIL rand_a cyc%0d got %b want %b", k, {ra, ova, oa, dna}, exp_of(0));
      end
      checks++;
      if ({rb, ovb, ob, dnb} !== exp_of(1)) begin
        errors++;
        $display("FAIL rand_b cyc%0d got %b want %b", k, {rb, ovb, ob, dnb}, exp_of(1));
      end
      if (ova) begin
        hist = {hist[2:0], oa}; nb++;
        if (nb >= 4 && hist == 4'b1011) det_dut++;
      end
    end
    va = 1'b0; vb = 1'b0;
    for (int k = 0; k < 2 * W; k++) begin
      step();
      if (ova) begin
        hist = {hist[2:0], oa}; nb++;
        if (nb >= 4 && hist == 4'b1011) det_dut++;
      end
    end
    rh = '0; rnb = 0; det_ref = 0;
    while (m_acc_q.size() > 0) begin
      p = m_acc_q.pop_front();
      for (int b = W - 1; b >= 0; b--) begin
        rh = {rh[2:0], p[b]}; rnb++;
        if (rnb >= 4 && rh == 4'b1011) det_ref++;
      end
    end
    checks++;
    if (nb != rnb || det_dut != det_ref) begin
      errors++;
      $display("FAIL loopback got %0d bits/%0d hits want %0d bits/%0d hits",
               nb, det_dut, rnb, det_ref);
    end
  endtask

  initial begin
    rst = 1'b1;
    va = 1'b0; vb = 1'b0; da = '0; db = '0;
    m_reset();
    test_reset();
    test_single();
    test_held_valid();
    test_ignored_input();
    test_mid_reset();
    test_gap0();
    test_random_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
